// File: rtl/decode_regfile.sv
// decode_regfile: Y86-64 SEQ decode stage plus the 15-entry architectural
// register file. Decodes source/destination register IDs from the current
// instruction, reads val_a/val_b combinationally and commits val_e/val_m
// on the rising clock edge. Register ID 0xF means "no register".
// Optional feature: define REGFILE_DEBUG_EN to add a third read port
// (dbg_sel/dbg_data) for dumping register state.
module decode_regfile #(
  parameter int unsigned      WIDTH    = 64,
  parameter logic [WIDTH-1:0] RSP_INIT = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [3:0]       in_code,
  input  logic [3:0]       ra,
  input  logic [3:0]       rb,
  input  logic             cnd,
  input  logic [WIDTH-1:0] val_e,
  input  logic [WIDTH-1:0] val_m,
  input  logic             wb_en,
`ifdef REGFILE_DEBUG_EN
  input  logic [3:0]       dbg_sel,
  output logic [WIDTH-1:0] dbg_data,
`endif
  output logic [WIDTH-1:0] val_a,
  output logic [WIDTH-1:0] val_b,
  output logic [3:0]       src_a,
  output logic [3:0]       src_b,
  output logic [3:0]       dst_e,
  output logic [3:0]       dst_m
);

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RRSP  = 4'h4;

  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // Only IDs 0..14 have storage; ID F never reaches the array.
  logic [WIDTH-1:0] regs_q [0:14];
  logic [WIDTH-1:0] regs_d [0:14];

  // Decode the four register IDs from icode, rA, rB and the cmov condition.
  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    dst_e = RNONE;
    dst_m = RNONE;
    case (in_code)
      I_RRMOVQ: begin
        src_a = ra;
        dst_e = cnd ? rb : RNONE;
      end
      I_IRMOVQ: dst_e = rb;
      I_RMMOVQ: begin
        src_a = ra;
        src_b = rb;
      end
      I_MRMOVQ: begin
        src_b = rb;
        dst_m = ra;
      end
      I_OPQ: begin
        src_a = ra;
        src_b = rb;
        dst_e = rb;
      end
      I_CALL: begin
        src_b = RRSP;
        dst_e = RRSP;
      end
      I_RET: begin
        src_a = RRSP;
        src_b = RRSP;
        dst_e = RRSP;
      end
      I_PUSHQ: begin
        src_a = ra;
        src_b = RRSP;
        dst_e = RRSP;
      end
      I_POPQ: begin
        src_a = RRSP;
        src_b = RRSP;
        dst_e = RRSP;
        dst_m = ra;
      end
      default: ;
    endcase
  end

  // Combinational reads of the committed state; ID F reads as zero.
  always_comb begin
    val_a = (src_a == RNONE) ? '0 : regs_q[src_a];
    val_b = (src_b == RNONE) ? '0 : regs_q[src_b];
  end

`ifdef REGFILE_DEBUG_EN
  // Debug read port, independent of the decode read ports.
  always_comb begin
    dbg_data = (dbg_sel == RNONE) ? '0 : regs_q[dbg_sel];
  end
`endif

  // Next register state: val_e first, then val_m so a popq %rsp keeps the
  // popped value.
  always_comb begin
    regs_d = regs_q;
    if (wb_en) begin
      if (dst_e != RNONE) regs_d[dst_e] = val_e;
      if (dst_m != RNONE) regs_d[dst_m] = val_m;
    end
  end

  // Register array with asynchronous reset; %rsp resets to RSP_INIT.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 15; i++) begin
        regs_q[i] <= (i == 4) ? RSP_INIT : '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

endmodule
